sd_dev_data_rx: RTL and testbench
=================================

// Module: sd_dev_data_rx
// PURPOSE
//  - Receive-side SD data-line engine for the device stack, directly downstream of the device platform PHY.
//  - Consumes the 4-bit data nibble sampled on each SD-clock rising-edge strobe (SDR, 4-bit bus).
//  - Per block: hunts the start bit, assembles bytes MSB-nibble-first and checks the per-line CRC16.
//  - Also checks the end bit, then reports status to the function/command layer.
// PARAMETERS
//  - BLK_W       12     width of i_block_size (max block 4095 bytes)
//  - TIMEOUT     1024   rising-edge strobes allowed in ST_WAIT before o_timeout
//  - TMO_W       11     width of timeout counter (must hold TIMEOUT)
// PORTS
//  - clk             in   1      SD x2 stack clock (same clock the PHY strobe is generated on)
//  - rst_n           in   1      asynchronous, active-low reset
//  - i_en            in   1      arm: 1-clk pulse starts one block reception; ignored unless idle
//  - i_block_size    in   BLK_W  bytes in block; latched on accepted i_en; 0 treated as 1
//  - i_posedge_stb   in   1      1-clk strobe: SD clock rising edge, i_sd_data_in valid
//  - i_sd_data_in    in   4      DAT[3:0] sampled by PHY (bit n = DATn)
//  - o_busy          out  1      high from accepted i_en until o_done
//  - o_data          out  8      assembled byte
//  - o_data_stb      out  1      1-clk pulse, o_data valid
//  - o_done          out  1      1-clk pulse, block finished (good or bad)
//  - o_crc_err       out  1      sticky until next accepted i_en: any line CRC mismatch
//  - o_end_err       out  1      sticky until next accepted i_en: end bit not 4'hF
//  - o_timeout       out  1      sticky until next accepted i_en: no start bit within TIMEOUT
// BEHAVIOUR
//  - Reset: all outputs 0; state ST_IDLE; counters and CRC registers 0.
//  - All data-path actions occur only on clk edges where i_posedge_stb=1; other cycles hold.
//  - FSM:
//    - ST_IDLE:  i_en -> latch size, clear sticky flags, CRC regs=0, o_busy=1, ST_WAIT.
//    - ST_WAIT:  stb & data==4'h0 -> ST_DATA.
//      - Otherwise stb increments tmo count.
//      - Count reaching TIMEOUT -> o_timeout=1, o_done pulse, ST_IDLE.
//    - ST_DATA:  first stb -> high nibble; second stb -> low nibble.
//      - Byte registered; o_data_stb on the clk after that second stb (latency 1 clk).
//      - After byte size-1 -> ST_CRC.
//    - ST_CRC:   16 stbs; each line's received bit is compared with MSB of its CRC reg.
//      - CRC reg then shifts left with 0.
//      - Any mismatch sets o_crc_err.
//    - ST_END:   next stb; data!=4'hF sets o_end_err; o_done pulse, o_busy=0, ST_IDLE.
//  - CRC: per line DATn, CRC16-CCITT x^16+x^12+x^5+1, init 0.
//    - Covers data bits only; start, CRC and end bits excluded.
//  - Bit ordering: byte = {first nibble, second nibble}.
//    - o_data[7:4] = DAT[3:0] of first stb; o_data[3:0] = DAT[3:0] of second stb.
//  - Byte counter BLK_W wide, counts 0..size-1; no wrap beyond size.
//  - No backpressure: consumer must accept every o_data_stb.
//  - i_en while o_busy: ignored. i_en with stb on the same clk: arming wins; the stb is not sampled.
//  - o_done and o_data_stb never coincide; the final o_data_stb precedes ST_CRC.
//  - rst_n low mid-block: immediate abort to reset values; no o_done.
// CONFIGURATION
//  - Macro SD_DEV_DATA_RX_CRC_EN.
//  - Defined: CRC generators and check as above.
//  - Undefined: no CRC logic; ST_CRC still consumes exactly 16 stbs; o_crc_err tied 0.
// STRUCTURE
//  - Shared package sd_dev_defines.vh holds:
//    - state encodings ST_IDLE/WAIT/DATA/CRC/END
//    - CRC16 polynomial constant 16'h1021
//    - start (4'h0) and end (4'hF) nibble constants
//  - One sub-module sd_crc16_serial:
//    - ports clk, rst_n, i_clear, i_en, i_bit, o_crc[15:0]
//    - instantiated 4x under the macro
// TESTING
//  - Directed scenarios:
//    - Reset, idle: o_busy/o_done/o_data_stb/flags all 0; stb noise with i_en=0 -> no activity.
//    - Size 4, start nibble, nibbles 1,2,3,4,5,6,7,8, correct CRC, end 4'hF.
//      - Required: o_data_stb x4 with bytes 0x12,0x34,0x56,0x78.
//      - Then o_done with all flags 0.
//    - Size 2, data 0x00,0x00:
//      - Each line CRC 16'h0000, so 16 nibbles 4'h0 then 4'hF -> o_done, o_crc_err=0.
//      - Same stimulus with one CRC nibble 4'h1 -> o_crc_err=1 (macro defined) / 0 (undefined).
//    - Valid block ending with nibble 4'hE -> o_done, o_end_err=1, o_crc_err=0.
//    - TIMEOUT=8, i_en then 8 stbs of 4'hF -> o_timeout=1, o_done pulse on the 8th; o_busy low.
//    - rst_n asserted after 3 bytes of size-8 block -> outputs 0 at once.
//      - Next i_en restarts cleanly and receives a full block.
//    - i_en pulsed during ST_DATA -> ignored; block completes with unchanged size.

Source files
------------

// File: rtl/sd_dev_data_rx_pkg.sv
// Shared definitions for the SD device data-line receiver: state encodings,
// CRC16-CCITT polynomial, start/end nibble constants and a one-bit CRC step.
package sd_dev_data_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_CRC  = 3'd3,
    ST_END  = 3'd4
  } state_e;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [3:0]  START_NIB  = 4'h0;
  localparam logic [3:0]  END_NIB    = 4'hF;

  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
    logic fb;
    fb = b ^ crc[15];
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/sd_dev_data_rx_crc16_serial.sv
// Bit-serial CRC16-CCITT generator for one SD data line (init 0).
// Feeding i_bit = o_crc[15] shifts the register left with zero fill.
module sd_crc16_serial
  import sd_dev_data_rx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_en,
  input  logic        i_bit,
  output logic [15:0] o_crc
);

  logic [15:0] crc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       crc_q <= '0;
    else if (i_clear) crc_q <= '0;
    else if (i_en)    crc_q <= crc16_step(crc_q, i_bit);
  end

  assign o_crc = crc_q;

endmodule

// File: rtl/sd_dev_data_rx.sv
// SD device receive data engine (4-bit SDR): start-bit hunt, byte assembly,
// per-line CRC16 check and end-bit check. CRC logic exists only when
// SD_DEV_DATA_RX_CRC_EN is defined; otherwise o_crc_err stays 0.
module sd_dev_data_rx
  import sd_dev_data_rx_pkg::*;
#(
  parameter int BLK_W   = 12,
  parameter int TIMEOUT = 1024,
  parameter int TMO_W   = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [BLK_W-1:0] i_block_size,
  input  logic             i_posedge_stb,
  input  logic [3:0]       i_sd_data_in,
  output logic             o_busy,
  output logic [7:0]       o_data,
  output logic             o_data_stb,
  output logic             o_done,
  output logic             o_crc_err,
  output logic             o_end_err,
  output logic             o_timeout
);

  state_e           state_q, state_d;
  logic [BLK_W-1:0] size_m1_q, size_m1_d;
  logic [BLK_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [3:0]       crc_cnt_q, crc_cnt_d;
  logic             nib_sel_q, nib_sel_d;
  logic [3:0]       hi_nib_q, hi_nib_d;
  logic [7:0]       data_q, data_d;
  logic             data_stb_q, data_stb_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             crc_err_q, crc_err_d;
  logic             end_err_q, end_err_d;
  logic             tmo_q, tmo_d;
  logic             crc_mis;

`ifdef SD_DEV_DATA_RX_CRC_EN
  logic             crc_clear, crc_en, crc_chk;
  logic [3:0][15:0] crc_line;
  logic [3:0]       crc_msb;

  assign crc_clear = (state_q == ST_IDLE) && i_en;
  assign crc_en    = i_posedge_stb && ((state_q == ST_DATA) || (state_q == ST_CRC));
  assign crc_chk   = i_posedge_stb && (state_q == ST_CRC);

  // In ST_CRC each generator is fed its own MSB so it shifts out with zero fill.
  for (genvar k = 0; k < 4; k++) begin : g_crc
    assign crc_msb[k] = crc_line[k][15];
    sd_crc16_serial u_crc (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clear (crc_clear),
      .i_en    (crc_en),
      .i_bit   ((state_q == ST_CRC) ? crc_msb[k] : i_sd_data_in[k]),
      .o_crc   (crc_line[k])
    );
  end

  assign crc_mis = crc_chk && (i_sd_data_in != crc_msb);
`else
  assign crc_mis = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    size_m1_d  = size_m1_q;
    byte_cnt_d = byte_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    crc_cnt_d  = crc_cnt_q;
    nib_sel_d  = nib_sel_q;
    hi_nib_d   = hi_nib_q;
    data_d     = data_q;
    data_stb_d = 1'b0;
    done_d     = 1'b0;
    busy_d     = busy_q;
    crc_err_d  = crc_err_q | crc_mis;
    end_err_d  = end_err_q;
    tmo_d      = tmo_q;
    case (state_q)
      ST_IDLE: if (i_en) begin
        // Arming takes priority; a coincident strobe is not sampled.
        size_m1_d  = (i_block_size == '0) ? '0 : i_block_size - 1'b1;
        byte_cnt_d = '0;
        tmo_cnt_d  = '0;
        crc_cnt_d  = '0;
        nib_sel_d  = 1'b0;
        crc_err_d  = 1'b0;
        end_err_d  = 1'b0;
        tmo_d      = 1'b0;
        busy_d     = 1'b1;
        state_d    = ST_WAIT;
      end
      ST_WAIT: if (i_posedge_stb) begin
        if (i_sd_data_in == START_NIB) begin
          state_d = ST_DATA;
        end else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
          tmo_d   = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      ST_DATA: if (i_posedge_stb) begin
        if (!nib_sel_q) begin
          hi_nib_d  = i_sd_data_in;
          nib_sel_d = 1'b1;
        end else begin
          nib_sel_d  = 1'b0;
          data_d     = {hi_nib_q, i_sd_data_in};
          data_stb_d = 1'b1;
          if (byte_cnt_q == size_m1_q) begin
            byte_cnt_d = '0;
            state_d    = ST_CRC;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end
      ST_CRC: if (i_posedge_stb) begin
        crc_cnt_d = crc_cnt_q + 1'b1;
        if (crc_cnt_q == 4'd15) state_d = ST_END;
      end
      ST_END: if (i_posedge_stb) begin
        if (i_sd_data_in != END_NIB) end_err_d = 1'b1;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      size_m1_q  <= '0;
      byte_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      crc_cnt_q  <= '0;
      nib_sel_q  <= 1'b0;
      hi_nib_q   <= '0;
      data_q     <= '0;
      data_stb_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      crc_err_q  <= 1'b0;
      end_err_q  <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      size_m1_q  <= size_m1_d;
      byte_cnt_q <= byte_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      crc_cnt_q  <= crc_cnt_d;
      nib_sel_q  <= nib_sel_d;
      hi_nib_q   <= hi_nib_d;
      data_q     <= data_d;
      data_stb_q <= data_stb_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      crc_err_q  <= crc_err_d;
      end_err_q  <= end_err_d;
      tmo_q      <= tmo_d;
    end
  end

  assign o_busy     = busy_q;
  assign o_data     = data_q;
  assign o_data_stb = data_stb_q;
  assign o_done     = done_q;
  assign o_crc_err  = crc_err_q;
  assign o_end_err  = end_err_q;
  assign o_timeout  = tmo_q;

endmodule

// File: tb/tb_sd_dev_data_rx.sv
// Directed bench for sd_dev_data_rx (TIMEOUT overridden to 8).
module tb_sd_dev_data_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_en = 1'b0;
  logic [11:0] i_block_size = '0;
  logic        i_posedge_stb = 1'b0;
  logic [3:0]  i_sd_data_in = '0;
  logic        o_busy, o_data_stb, o_done, o_crc_err, o_end_err, o_timeout;
  logic [7:0]  o_data;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [7:0] rx_q[$];
  logic [7:0] blk[16];

`ifdef SD_DEV_DATA_RX_CRC_EN
  localparam logic CRC_ON = 1'b1;
`else
  localparam logic CRC_ON = 1'b0;
`endif

  sd_dev_data_rx #(.BLK_W(12), .TIMEOUT(8), .TMO_W(11)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_en          (i_en),
    .i_block_size  (i_block_size),
    .i_posedge_stb (i_posedge_stb),
    .i_sd_data_in  (i_sd_data_in),
    .o_busy        (o_busy),
    .o_data        (o_data),
    .o_data_stb    (o_data_stb),
    .o_done        (o_done),
    .o_crc_err     (o_crc_err),
    .o_end_err     (o_end_err),
    .o_timeout     (o_timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_data_stb) rx_q.push_back(o_data);
    if (o_done)     done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic stb(input logic [3:0] n);
    @(negedge clk);
    i_posedge_stb = 1'b1;
    i_sd_data_in  = n;
    @(negedge clk);
    i_posedge_stb = 1'b0;
  endtask

  task automatic arm(input logic [11:0] sz);
    @(negedge clk);
    i_en = 1'b1;
    i_block_size = sz;
    @(negedge clk);
    i_en = 1'b0;
  endtask

  // Sends start, n bytes from blk, 16 CRC nibbles (one optionally replaced)
  // and the end nibble; optionally pulses i_en after en_at data nibbles.
  task automatic send_block(input int n, input int flip_idx, input logic [3:0] flip_val,
                            input logic [3:0] endn, input int en_at);
    logic [15:0] crc[4];
    logic [3:0]  nib, c;
    for (int k = 0; k < 4; k++) crc[k] = '0;
    stb(4'h0);
    for (int i = 0; i < 2 * n; i++) begin
      if (i == en_at) begin
        i_en = 1'b1;
        i_block_size = 12'd5;
        @(negedge clk);
        i_en = 1'b0;
      end
      nib = (i % 2 == 0) ? blk[i/2][7:4] : blk[i/2][3:0];
      for (int k = 0; k < 4; k++)
        crc[k] = {crc[k][14:0], 1'b0} ^ ((nib[k] ^ crc[k][15]) ? 16'h1021 : 16'h0);
      stb(nib);
    end
    for (int j = 0; j < 16; j++) begin
      for (int k = 0; k < 4; k++) c[k] = crc[k][15-j];
      stb((j == flip_idx) ? flip_val : c);
    end
    stb(endn);
  endtask

  initial begin
    idle(2);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_dstb", o_data_stb, 0);
    chk("rst_flags", {o_crc_err, o_end_err, o_timeout}, 0);
    rst_n = 1'b1;
    idle(2);
    for (int i = 0; i < 5; i++) stb(4'(i));
    idle(2);
    chk("noise_busy", o_busy, 0);
    chk("noise_act", rx_q.size() + done_cnt, 0);

    // Size 4, bytes 0x12..0x78 with correct CRC
    blk[0] = 8'h12; blk[1] = 8'h34; blk[2] = 8'h56; blk[3] = 8'h78;
    arm(12'd4);
    chk("arm_busy", o_busy, 1);
    send_block(4, -1, 4'h0, 4'hF, -1);
    chk("b4_done", o_done, 1);
    chk("b4_busy", o_busy, 0);
    chk("b4_flags", {o_crc_err, o_end_err, o_timeout}, 0);
    idle(2);
    chk("b4_nbytes", rx_q.size(), 4);
    chk("b4_byte0", rx_q[0], 8'h12);
    chk("b4_byte1", rx_q[1], 8'h34);
    chk("b4_byte2", rx_q[2], 8'h56);
    chk("b4_byte3", rx_q[3], 8'h78);
    chk("b4_ndone", done_cnt, 1);
    rx_q.delete(); done_cnt = 0;

    // Size 2 zeros, good CRC then one corrupted CRC nibble
    blk[0] = 8'h00; blk[1] = 8'h00;
    arm(12'd2);
    send_block(2, -1, 4'h0, 4'hF, -1);
    chk("z_done", o_done, 1);
    chk("z_crc", o_crc_err, 0);
    arm(12'd2);
    send_block(2, 5, 4'h1, 4'hF, -1);
    chk("zbad_done", o_done, 1);
    chk("zbad_crc", o_crc_err, CRC_ON);
    chk("zbad_end", o_end_err, 0);
    arm(12'd2);
    chk("zbad_clr", o_crc_err, 0);
    send_block(2, -1, 4'h0, 4'hF, -1);
    idle(1);
    rx_q.delete(); done_cnt = 0;

    // Bad end nibble; size 0 treated as one byte
    blk[0] = 8'hA5;
    arm(12'd0);
    send_block(1, -1, 4'h0, 4'hE, -1);
    chk("end_done", o_done, 1);
    chk("end_err", o_end_err, 1);
    chk("end_crc", o_crc_err, 0);
    idle(1);
    chk("end_nbytes", rx_q.size(), 1);
    chk("end_byte", rx_q[0], 8'hA5);
    rx_q.delete(); done_cnt = 0;

    // Timeout after 8 non-start strobes
    arm(12'd1);
    for (int i = 0; i < 7; i++) stb(4'hF);
    chk("tmo_early", o_done | o_timeout, 0);
    stb(4'hF);
    chk("tmo_done", o_done, 1);
    chk("tmo_flag", o_timeout, 1);
    chk("tmo_busy", o_busy, 0);
    idle(2);
    chk("tmo_hold", o_timeout, 1);
    done_cnt = 0;

    // Reset mid-block after three bytes of a size-8 block
    arm(12'd8);
    stb(4'h0);
    for (int i = 0; i < 6; i++) stb(4'(i + 1));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", o_busy, 0);
    chk("rst_mid_out", {o_data, o_data_stb, o_done, o_crc_err, o_end_err, o_timeout}, 0);
    idle(2);
    rst_n = 1'b1;
    rx_q.delete(); done_cnt = 0;
    for (int i = 0; i < 8; i++) blk[i] = 8'(8'h11 * (i + 1));
    arm(12'd8);
    send_block(8, -1, 4'h0, 4'hF, -1);
    chk("rec_done", o_done, 1);
    chk("rec_flags", {o_crc_err, o_end_err, o_timeout}, 0);
    idle(1);
    chk("rec_nbytes", rx_q.size(), 8);
    chk("rec_byte7", rx_q[7], 8'h88);
    rx_q.delete(); done_cnt = 0;

    // i_en during ST_DATA is ignored
    blk[0] = 8'hC3; blk[1] = 8'h3C;
    arm(12'd2);
    send_block(2, -1, 4'h0, 4'hF, 1);
    chk("ign_done", o_done, 1);
    chk("ign_crc", o_crc_err, 0);
    idle(3);
    chk("ign_nbytes", rx_q.size(), 2);
    chk("ign_byte1", rx_q[1], 8'h3C);
    chk("ign_ndone", done_cnt, 1);
    chk("ign_busy", o_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
